// File: rtl/bus_transfer_arbiter_if.sv
// Bus transfer arbiter interface: requester-side request/payload signals and
// arbiter-side grant, bus-mux select and register load-enable signals.
// Optional BUS_ARB_LOCK_EN adds a per-requester lock line.
interface bus_transfer_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SEL_W   = 5,
    parameter int unsigned DST_W   = 32
);
    localparam int unsigned DIDX_W = 5;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*SEL_W-1:0]  src_sel;
    logic [NUM_REQ*DIDX_W-1:0] dst_idx;
`ifdef BUS_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        lock;
`endif
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [SEL_W-1:0]          bus_select;
    logic [DST_W-1:0]          dst_load;
    logic                      busy;
    logic                      err;

`ifdef BUS_ARB_LOCK_EN
    modport master (output req, src_sel, dst_idx, lock,
                    input  gnt, done, bus_select, dst_load, busy, err);
    modport slave  (input  req, src_sel, dst_idx, lock,
                    output gnt, done, bus_select, dst_load, busy, err);
`else
    modport master (output req, src_sel, dst_idx,
                    input  gnt, done, bus_select, dst_load, busy, err);
    modport slave  (input  req, src_sel, dst_idx,
                    output gnt, done, bus_select, dst_load, busy, err);
`endif
endinterface

// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter sharing the processor bus between NUM_REQ requesters.
// Each transfer: DRIVE (bus settle, mux select driven) then LOAD (one-hot
// destination load enable plus done pulse). Back-to-back transfers go
// LOAD -> DRIVE directly for one transfer every two cycles.
// Optional feature macro BUS_ARB_LOCK_EN: lock input lets the current winner be
// re-granted up to 4 consecutive transfers before rotation is forced.
module bus_transfer_arbiter #(
    parameter int unsigned      NUM_REQ  = 4,
    parameter int unsigned      SEL_W    = 5,
    parameter int unsigned      DST_W    = 32,
    parameter logic [SEL_W-1:0] IDLE_SEL = SEL_W'(31)
) (
    input logic                   clock,
    input logic                   clear_n,
    bus_transfer_arbiter_if.slave bus
);
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DIDX_W = 5;
`ifdef BUS_ARB_LOCK_EN
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned LOCK_MAX = 4;
`endif

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]    src_q, src_d;
    logic [DIDX_W-1:0]   dst_q, dst_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [SEL_W-1:0]    bus_select_q, bus_select_d;
    logic [DST_W-1:0]    dst_load_q, dst_load_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
`ifdef BUS_ARB_LOCK_EN
    logic [CNT_W-1:0]    streak_q, streak_d;
    logic                regrant_c;
`endif

    logic [IDX_W:0]      pick_c;
    logic                grant_c;
    logic [IDX_W-1:0]    grant_idx_c;

    // First set bit of mask searching upward from base+1 (wrapping); MSB = hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [IDX_W-1:0]   base);
        logic [IDX_W:0] res;
        int unsigned    idx;
        res = '0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            idx = 32'(base) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (mask[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    // State and registered outputs.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= IDLE;
            win_q        <= '0;
            rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
            src_q        <= '0;
            dst_q        <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            bus_select_q <= IDLE_SEL;
            dst_load_q   <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef BUS_ARB_LOCK_EN
            streak_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            rr_ptr_q     <= rr_ptr_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            bus_select_q <= bus_select_d;
            dst_load_q   <= dst_load_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
`ifdef BUS_ARB_LOCK_EN
            streak_q     <= streak_d;
`endif
        end
    end

    // Next-state, arbitration, capture and next output values.
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        rr_ptr_d     = rr_ptr_q;
        src_d        = src_q;
        dst_d        = dst_q;
        gnt_d        = '0;
        done_d       = '0;
        bus_select_d = IDLE_SEL;
        dst_load_d   = '0;
        busy_d       = 1'b0;
        err_d        = 1'b0;
        pick_c       = '0;
        grant_c      = 1'b0;
        grant_idx_c  = '0;
`ifdef BUS_ARB_LOCK_EN
        streak_d     = streak_q;
        regrant_c    = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                pick_c = rr_pick(bus.req, rr_ptr_q);
                if (pick_c[IDX_W]) begin
                    grant_c     = 1'b1;
                    grant_idx_c = pick_c[IDX_W-1:0];
                end
            end
            DRIVE: begin
                if (bus.req[win_q]) begin
                    state_d      = LOAD;
                    gnt_d        = NUM_REQ'(1) << win_q;
                    done_d       = NUM_REQ'(1) << win_q;
                    busy_d       = 1'b1;
                    bus_select_d = src_q;
                    if (32'(dst_q) < DST_W) dst_load_d = DST_W'(1) << dst_q;
                    else                    err_d      = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d  = IDLE;
                rr_ptr_d = win_q;
`ifdef BUS_ARB_LOCK_EN
                if (bus.lock[win_q] && bus.req[win_q] && (streak_q < CNT_W'(LOCK_MAX))) begin
                    regrant_c   = 1'b1;
                    grant_c     = 1'b1;
                    grant_idx_c = win_q;
                end else begin
                    pick_c = rr_pick(bus.req & ~(NUM_REQ'(1) << win_q), win_q);
                    if (pick_c[IDX_W]) begin
                        grant_c     = 1'b1;
                        grant_idx_c = pick_c[IDX_W-1:0];
                    end
                end
`else
                pick_c = rr_pick(bus.req & ~(NUM_REQ'(1) << win_q), win_q);
                if (pick_c[IDX_W]) begin
                    grant_c     = 1'b1;
                    grant_idx_c = pick_c[IDX_W-1:0];
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (grant_c) begin
            state_d      = DRIVE;
            win_d        = grant_idx_c;
            src_d        = bus.src_sel[32'(grant_idx_c) * SEL_W +: SEL_W];
            dst_d        = bus.dst_idx[32'(grant_idx_c) * DIDX_W +: DIDX_W];
            gnt_d        = NUM_REQ'(1) << grant_idx_c;
            busy_d       = 1'b1;
            bus_select_d = src_d;
`ifdef BUS_ARB_LOCK_EN
            streak_d     = regrant_c ? (streak_q + CNT_W'(1)) : CNT_W'(1);
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.bus_select = bus_select_q;
    assign bus.dst_load   = dst_load_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Scoreboard bench for bus_transfer_arbiter (NUM_REQ=4, DST_W=24).
// Stimulus pushes the expected LOAD-cycle response per transfer; the monitor
// pops and compares on every done pulse. Lock test runs when BUS_ARB_LOCK_EN is set.
module tb_bus_transfer_arbiter;
    typedef struct packed {
        logic [3:0]  done;
        logic [23:0] load;
        logic        err;
        logic [4:0]  sel;
    } exp_t;

    logic clk;
    logic clear_n;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    bus_transfer_arbiter_if #(.NUM_REQ(4), .SEL_W(5), .DST_W(24)) bus ();

    bus_transfer_arbiter #(
        .NUM_REQ (4),
        .SEL_W   (5),
        .DST_W   (24),
        .IDLE_SEL(5'd31)
    ) dut (
        .clock  (clk),
        .clear_n(clear_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int idx, input logic [4:0] src, input logic [4:0] dst);
        exp_t e;
        e.done = 4'(1) << idx;
        e.load = (dst < 5'd24) ? (24'(1) << dst) : 24'd0;
        e.err  = (dst >= 5'd24);
        e.sel  = src;
        return e;
    endfunction

    task automatic set_src(input int i, input logic [4:0] src, input logic [4:0] dst);
        bus.src_sel[i*5 +: 5] = src;
        bus.dst_idx[i*5 +: 5] = dst;
    endtask

    // Requesters hold req until their own done pulse.
    task automatic serve(input logic [3:0] mask);
        bus.req = mask;
        for (int c = 0; c < 60 && bus.req != 4'b0; c++) begin
            @(posedge clk);
            #1;
            bus.req = bus.req & ~bus.done;
        end
        if (bus.req != 4'b0) chk("serve_timeout", 32'(bus.req), 32'd0);
        bus.req = 4'b0;
    endtask

    // Hold a fixed request pattern for n edges, then drop it.
    task automatic hold(input logic [3:0] mask, input int n);
        @(posedge clk);
        #1 bus.req = mask;
        repeat (n) @(posedge clk);
        #1 bus.req = 4'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) break;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},      32'(bus.gnt),        32'd0);
        chk({tag, "_done"},     32'(bus.done),       32'd0);
        chk({tag, "_dst_load"}, 32'(bus.dst_load),   32'd0);
        chk({tag, "_busy"},     32'(bus.busy),       32'd0);
        chk({tag, "_err"},      32'(bus.err),        32'd0);
        chk({tag, "_sel"},      32'(bus.bus_select), 32'd31);
    endtask

    // Monitor: every done pulse must match the next expected transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (clear_n) begin
                if (bus.done != 4'b0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'(bus.done), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done",       32'(bus.done),       32'(e.done));
                        chk("gnt_load",   32'(bus.gnt),        32'(e.done));
                        chk("dst_load",   32'(bus.dst_load),   32'(e.load));
                        chk("err",        32'(bus.err),        32'(e.err));
                        chk("bus_select", 32'(bus.bus_select), 32'(e.sel));
                    end
                end else begin
                    chk("load_without_done", 32'(bus.dst_load), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        clear_n     = 1'b0;
        bus.req     = '0;
        bus.src_sel = '0;
        bus.dst_idx = '0;
`ifdef BUS_ARB_LOCK_EN
        bus.lock    = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk);
        #1 clear_n = 1'b1;

        // Single transfer with latency and return-to-idle checks.
        @(posedge clk);
        #1 set_src(0, 5'd3, 5'd7);
        exp_q.push_back(mk(0, 5'd3, 5'd7));
        bus.req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        chk("t1_gnt",  32'(bus.gnt),        32'h1);
        chk("t1_sel",  32'(bus.bus_select), 32'd3);
        chk("t1_busy", 32'(bus.busy),       32'd1);
        chk("t1_done", 32'(bus.done),       32'd0);
        @(posedge clk);
        #1 bus.req = 4'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t1_idle_sel",  32'(bus.bus_select), 32'd31);
        chk("t1_idle_busy", 32'(bus.busy),       32'd0);
        chk("t1_idle_gnt",  32'(bus.gnt),        32'd0);
        wait_drain("t1_drain");

        // Re-reset so requester 0 has top priority, then continuous 1111.
        @(posedge clk);
        #1 clear_n = 1'b0;
        @(posedge clk);
        #1 clear_n = 1'b1;
        for (int i = 0; i < 4; i++) set_src(i, 5'(10 + i), 5'(2 + 3 * i));
        exp_q.push_back(mk(0, 5'd10, 5'd2));
        exp_q.push_back(mk(1, 5'd11, 5'd5));
        exp_q.push_back(mk(2, 5'd12, 5'd8));
        exp_q.push_back(mk(3, 5'd13, 5'd11));
        exp_q.push_back(mk(0, 5'd10, 5'd2));
        hold(4'b1111, 10);
        wait_drain("t2_drain");

        // rr_ptr to 1, then abort a grant to 2 in DRIVE.
        set_src(1, 5'd4, 5'd1);
        exp_q.push_back(mk(1, 5'd4, 5'd1));
        serve(4'b0010);
        wait_drain("t3a_drain");
        set_src(2, 5'd6, 5'd9);
        @(posedge clk);
        #1 bus.req = 4'b0100;
        @(posedge clk);
        #1 bus.req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk("t3_abort_busy", 32'(bus.busy),     32'd0);
        chk("t3_abort_gnt",  32'(bus.gnt),      32'd0);
        chk("t3_abort_done", 32'(bus.done),     32'd0);
        chk("t3_abort_load", 32'(bus.dst_load), 32'd0);
        // Search still starts at 2: 2 beats 0.
        set_src(0, 5'd2, 5'd3);
        exp_q.push_back(mk(2, 5'd6, 5'd9));
        exp_q.push_back(mk(0, 5'd2, 5'd3));
        serve(4'b0101);
        wait_drain("t3_drain");

        // Inputs changed after grant are ignored for that transfer.
        set_src(1, 5'd12, 5'd4);
        exp_q.push_back(mk(1, 5'd12, 5'd4));
        @(posedge clk);
        #1 bus.req = 4'b0010;
        @(posedge clk);
        #1 set_src(1, 5'd20, 5'd15);
        serve(4'b0010);
        wait_drain("cap_drain");

        // Reset during LOAD.
        set_src(0, 5'd9, 5'd10);
        @(posedge clk);
        #1 bus.req = 4'b0001;
        @(posedge clk);
        @(posedge clk);
        #1 chk("t4_in_load", 32'(bus.done), 32'h1);
        #1 clear_n = 1'b0;
        bus.req = 4'b0;
        #1 chk_idle("t4_reset");
        @(posedge clk);
        #1 clear_n = 1'b1;
        set_src(0, 5'd1, 5'd2);
        set_src(3, 5'd17, 5'd20);
        exp_q.push_back(mk(0, 5'd1, 5'd2));
        exp_q.push_back(mk(3, 5'd17, 5'd20));
        serve(4'b1001);
        wait_drain("t4_drain");

        // Destination range: 31 and 24 out of range, 23 last valid.
        set_src(0, 5'd7, 5'd31);
        set_src(1, 5'd8, 5'd23);
        set_src(2, 5'd9, 5'd24);
        exp_q.push_back(mk(0, 5'd7, 5'd31));
        exp_q.push_back(mk(1, 5'd8, 5'd23));
        exp_q.push_back(mk(2, 5'd9, 5'd24));
        serve(4'b0111);
        wait_drain("t5_drain");

`ifdef BUS_ARB_LOCK_EN
        // Lock: requester 0 re-granted 4 times, then 1, then 0.
        set_src(0, 5'd3, 5'd0);
        set_src(1, 5'd4, 5'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 5'd3, 5'd0));
        exp_q.push_back(mk(1, 5'd4, 5'd1));
        exp_q.push_back(mk(0, 5'd3, 5'd0));
        bus.lock = 4'b0001;
        hold(4'b0011, 12);
        bus.lock = 4'b0000;
        wait_drain("t6_drain");
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
